// File: rtl/conv33_window.sv
// Raster pixel stream to 3x3 window generator: two line buffers feed three 3-tap column shifters.
// conv33_en pulses one clock after each accept that completes a valid (unpadded) window.
module conv33_window #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [DATA_WIDTH-1:0] data_0_0,
  output logic [DATA_WIDTH-1:0] data_0_1,
  output logic [DATA_WIDTH-1:0] data_0_2,
  output logic [DATA_WIDTH-1:0] data_1_0,
  output logic [DATA_WIDTH-1:0] data_1_1,
  output logic [DATA_WIDTH-1:0] data_1_2,
  output logic [DATA_WIDTH-1:0] data_2_0,
  output logic [DATA_WIDTH-1:0] data_2_1,
  output logic [DATA_WIDTH-1:0] data_2_2,
  output logic                  conv33_en,
  output logic                  frame_done
);
  localparam int MAXD  = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CNT_W = $clog2(MAXD) + 1;
  localparam int AW    = $clog2(IMG_W);

  logic [CNT_W-1:0] row, col;
  logic [CNT_W-1:0] row_eff, col_eff;
  logic [AW-1:0]    col_idx;
  logic             accept;
  logic             col_last, row_last;

  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] rd0, rd1;

  // win[i][j]: i = window row (0 oldest), j = column (0 oldest)
  logic [2:0][2:0][DATA_WIDTH-1:0] win;

  assign accept   = pix_valid;
  // sof restarts the frame: the pixel is handled as though the counters were at 0,0
  assign row_eff  = pix_sof ? '0 : row;
  assign col_eff  = pix_sof ? '0 : col;
  assign col_idx  = col_eff[AW-1:0];
  assign col_last = (col_eff == CNT_W'(IMG_W - 1));
  assign row_last = (row_eff == CNT_W'(IMG_H - 1));
  assign rd0      = lb0[col_idx];
  assign rd1      = lb1[col_idx];

  // Line buffers are never cleared; stale rows are masked by the row>=2 gate.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      lb0[col_idx] <= rd1;
      lb1[col_idx] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      win        <= '0;
      conv33_en  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      conv33_en  <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= rd0;
        win[1][2] <= rd1;
        win[2][2] <= pix_in;

        conv33_en  <= (row_eff >= CNT_W'(2)) && (col_eff >= CNT_W'(2));
        frame_done <= row_last && col_last;

        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row_eff + CNT_W'(1);
        end else begin
          col <= col_eff + CNT_W'(1);
          row <= row_eff;
        end
      end
    end
  end

  assign data_0_0 = win[0][0];
  assign data_0_1 = win[0][1];
  assign data_0_2 = win[0][2];
  assign data_1_0 = win[1][0];
  assign data_1_1 = win[1][1];
  assign data_1_2 = win[1][2];
  assign data_2_0 = win[2][0];
  assign data_2_1 = win[2][1];
  assign data_2_2 = win[2][2];
endmodule

// File: tb/tb_conv33_window.sv
// Directed bench for conv33_window: a 4x4 instance for stream/window behaviour, a 3x3 instance for the signed corner.
module tb_conv33_window;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, pix_valid, pix_sof;
  logic [7:0] pix_in;
  logic [7:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
  logic       conv33_en, frame_done;

  logic       v3, s3;
  logic [7:0] p3;
  logic [7:0] e00, e01, e02, e10, e11, e12, e20, e21, e22;
  logic       en3, fd3;

  conv33_window #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_in(pix_in),
    .data_0_0(d00), .data_0_1(d01), .data_0_2(d02),
    .data_1_0(d10), .data_1_1(d11), .data_1_2(d12),
    .data_2_0(d20), .data_2_1(d21), .data_2_2(d22),
    .conv33_en(conv33_en), .frame_done(frame_done));

  conv33_window #(.DATA_WIDTH(8), .IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .pix_valid(v3), .pix_sof(s3), .pix_in(p3),
    .data_0_0(e00), .data_0_1(e01), .data_0_2(e02),
    .data_1_0(e10), .data_1_1(e11), .data_1_2(e12),
    .data_2_0(e20), .data_2_1(e21), .data_2_2(e22),
    .conv33_en(en3), .frame_done(fd3));

  logic [71:0] taps, taps3;
  assign taps  = {d00, d01, d02, d10, d11, d12, d20, d21, d22};
  assign taps3 = {e00, e01, e02, e10, e11, e12, e20, e21, e22};

  typedef struct packed {
    logic [71:0] taps;
    logic        fd;
  } win_t;

  win_t q[$];
  int   fd_cnt, fd_alone, viol;
  logic last_acc = 1'b0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk) last_acc <= rst_n && pix_valid;

  always @(negedge clk) begin
    if (conv33_en) q.push_back('{taps: taps, fd: frame_done});
    if (frame_done) fd_cnt++;
    if (frame_done && !conv33_en) fd_alone++;
    if (conv33_en && !last_acc) viol++;
  end

  // window at (r,c) of a 4x4 frame whose pixels are base + r*4 + c
  function automatic logic [71:0] exp_win(input int base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (i*3 + j))*8 +: 8] = 8'(base + (r - 2 + i)*4 + (c - 2 + j));
    return w;
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    pix_valid = v; pix_sof = s; pix_in = d;
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_in = 8'h00;
  endtask

  task automatic send_frame(input int base, input int gap, input logic sof);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, sof && (k == 0), 8'(base + k));
      repeat (gap) drive(1'b0, 1'b0, 8'h00);
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_mon();
    q.delete(); fd_cnt = 0; fd_alone = 0; viol = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = 8'h00;
    v3 = 1'b0; s3 = 1'b0; p3 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (taps !== 72'h0) $display("FAIL reset_taps got %h want 0", taps); else n_pass++;
    n_chk++; if (conv33_en !== 1'b0) $display("FAIL reset_en got %b want 0", conv33_en); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    clear_mon();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, k == 0, 8'(k));
      if (k == 9) begin
        n_chk++; if (conv33_en !== 1'b0) $display("FAIL early_en got %b want 0", conv33_en); else n_pass++;
      end
      if (k == 10) begin
        n_chk++; if (conv33_en !== 1'b1) $display("FAIL first_en got %b want 1", conv33_en); else n_pass++;
        n_chk++; if (taps !== exp_win(0, 2, 2)) $display("FAIL first_taps got %h want %h", taps, exp_win(0, 2, 2)); else n_pass++;
      end
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    n_chk++; if (q.size() != 4) $display("FAIL frame_count got %0d want 4", q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (k >= q.size()) $display("FAIL frame_win%0d missing", k);
      else if (q[k] !== {exp_win(0, 2 + k/2, 2 + k%2), 1'(k == 3)})
        $display("FAIL frame_win%0d got %h want %h", k, q[k], {exp_win(0, 2 + k/2, 2 + k%2), 1'(k == 3)});
      else n_pass++;
    end
    n_chk++; if (fd_cnt != 1 || fd_alone != 0) $display("FAIL frame_fd got %0d/%0d want 1/0", fd_cnt, fd_alone); else n_pass++;
  endtask

  task automatic test_gaps();
    clear_mon();
    send_frame(0, 2, 1'b0);
    n_chk++; if (q.size() != 4) $display("FAIL gaps_count got %0d want 4", q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (k >= q.size()) $display("FAIL gaps_win%0d missing", k);
      else if (q[k] !== {exp_win(0, 2 + k/2, 2 + k%2), 1'(k == 3)})
        $display("FAIL gaps_win%0d got %h want %h", k, q[k], {exp_win(0, 2 + k/2, 2 + k%2), 1'(k == 3)});
      else n_pass++;
    end
    n_chk++; if (viol != 0) $display("FAIL gaps_en_after_idle got %0d want 0", viol); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int k = 0; k < 32; k++) drive(1'b1, 1'b0, 8'((k < 16) ? k : 100 + k - 16));
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    n_chk++; if (q.size() != 8) $display("FAIL b2b_count got %0d want 8", q.size()); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (k >= q.size()) $display("FAIL b2b_win%0d missing", k);
      else if (q[k] !== {exp_win((k < 4) ? 0 : 100, 2 + (k%4)/2, 2 + k%2), 1'(k%4 == 3)})
        $display("FAIL b2b_win%0d got %h want %h", k, q[k], {exp_win((k < 4) ? 0 : 100, 2 + (k%4)/2, 2 + k%2), 1'(k%4 == 3)});
      else n_pass++;
    end
    n_chk++; if (fd_cnt != 2) $display("FAIL b2b_fd got %0d want 2", fd_cnt); else n_pass++;
  endtask

  task automatic test_sof_abort();
    clear_mon();
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 8'(k));
    send_frame(50, 0, 1'b1);
    n_chk++; if (q.size() != 4) $display("FAIL sof_count got %0d want 4", q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (k >= q.size()) $display("FAIL sof_win%0d missing", k);
      else if (q[k].taps !== exp_win(50, 2 + k/2, 2 + k%2))
        $display("FAIL sof_win%0d got %h want %h", k, q[k].taps, exp_win(50, 2 + k/2, 2 + k%2));
      else n_pass++;
    end
    n_chk++; if (fd_cnt != 1) $display("FAIL sof_fd got %0d want 1", fd_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 8'(k));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_chk++;
    if ({taps, conv33_en, frame_done} !== 74'h0)
      $display("FAIL midrst_out got %h want 0", {taps, conv33_en, frame_done});
    else n_pass++;
    send_frame(20, 0, 1'b0);
    n_chk++; if (q.size() != 4) $display("FAIL midrst_count got %0d want 4", q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (k >= q.size()) $display("FAIL midrst_win%0d missing", k);
      else if (q[k] !== {exp_win(20, 2 + k/2, 2 + k%2), 1'(k == 3)})
        $display("FAIL midrst_win%0d got %h want %h", k, q[k], {exp_win(20, 2 + k/2, 2 + k%2), 1'(k == 3)});
      else n_pass++;
    end
  endtask

  task automatic test_signed();
    for (int k = 0; k < 9; k++) begin
      v3 = 1'b1; s3 = (k == 0); p3 = 8'h80;
      @(posedge clk); #1;
      v3 = 1'b0; s3 = 1'b0;
      if (k == 7) begin
        n_chk++; if (en3 !== 1'b0) $display("FAIL signed_early got %b want 0", en3); else n_pass++;
      end
    end
    n_chk++; if (en3 !== 1'b1) $display("FAIL signed_en got %b want 1", en3); else n_pass++;
    n_chk++; if (taps3 !== {9{8'h80}}) $display("FAIL signed_taps got %h want %h", taps3, {9{8'h80}}); else n_pass++;
    n_chk++; if (fd3 !== 1'b1) $display("FAIL signed_fd got %b want 1", fd3); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (en3 !== 1'b0) $display("FAIL signed_single got %b want 0", en3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_back_to_back();
    test_sof_abort();
    test_reset_mid();
    test_signed();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
